collision_resolver_seq: RTL and testbench
=========================================

Name: collision_resolver_seq

Overview:
- Sequential, handshaked, parametrised successor to the combinational two-ball collision velocity block.
- Resolves an equal-mass 2D ball collision with a runtime coefficient of restitution.
- Detects separating and degenerate (coincident) pairs and passes their velocities through unchanged.
- Sits between the collision detector and the physics state update; uses valid/ready on input and output, and computes the contact normal iteratively (sqrt, then divide) rather than with one long combinational path.

Parameters:
- WIDTH, 32, total bits of every signed fixed-point operand.
- FRAC_WIDTH, 30, fractional bits; ONE = 2^FRAC_WIDTH.
- TOL_LSB, 4, documented accuracy bound in LSBs used by verification (no RTL effect).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input pair valid
- in_ready  out  1  block idle and able to accept
- x0, y0, x1, y1  in  WIDTH each  ball positions, signed Q(FRAC_WIDTH)
- v0_x, v0_y, v1_x, v1_y  in  WIDTH each  ball velocities
- restitution  in  WIDTH  coefficient e, valid range [0, ONE]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- new_v0_x, new_v0_y, new_v1_x, new_v1_y  out  WIDTH each  resolved velocities
- separating  out  1  pair not approaching, outputs are pass-through
- degenerate  out  1  positions coincide, outputs are pass-through

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous, active-low. While rst=0: state IDLE, in_ready=0, out_valid=0, all velocity outputs 0, separating=0, degenerate=0.
  - in_ready rises the first cycle after rst deasserts.
  - Reset mid-operation aborts the current computation and discards it; no out_valid is produced for that pair.
- Input handshake:
  - in_ready=1 only in IDLE.
  - A transfer occurs on an edge with in_valid&in_ready.
  - All inputs, including restitution, are registered on transfer. Later input changes have no effect on that pair.
- FSM states: IDLE, DIFF, MAG, SQRT, DIV, DOT, IMPULSE, APPLY, HOLD.
  - IDLE -> DIFF on transfer.
  - DIFF: dx=x1-x0, dy=y1-y0, rvx=v1_x-v0_x, rvy=v1_y-v0_y.
  - MAG: d2=dx*dx+dy*dy at full 2*WIDTH precision, Q(2*FRAC_WIDTH). If d2==0: set degenerate, load pass-through, go to HOLD.
  - SQRT: WIDTH iterations of the bit-serial sqrt sub-module; d = sqrt(d2) in Q(FRAC_WIDTH), truncated.
  - DIV: two parallel restoring dividers, WIDTH iterations, computing nx=dx/d and ny=dy/d in Q(FRAC_WIDTH), truncated toward zero.
  - DOT: vn = rvx*nx + rvy*ny.
  - IMPULSE:
    - If vn >= 0: set separating, load pass-through, go to HOLD.
    - Otherwise: k = (ONE+restitution)>>>1, then s = k*vn.
  - APPLY: new_v0 = v0 + s*n; new_v1 = v1 - s*n; go to HOLD.
  - HOLD: out_valid=1; outputs and flags stable until out_valid&out_ready, then IDLE.
- Latency:
  - Normal path: out_valid asserts exactly 2*WIDTH+5 cycles after the transfer edge.
  - Degenerate path: 2 cycles after the transfer edge.
  - Separating path: 2*WIDTH+4 cycles after the transfer edge.
  - Throughput is one pair per latency plus one handshake cycle; the block is not pipelined.
- Arithmetic:
  - Every fixed-point product is the full 2*WIDTH signed product arithmetic-shifted right by FRAC_WIDTH and truncated to WIDTH bits.
  - Add and subtract are two's-complement wrap, no saturation.
  - restitution outside [0, ONE] gives an unspecified result.
- Flags: separating and degenerate are mutually exclusive; both are 0 on the normal path. Both are valid only with out_valid.
- out_ready held high while out_valid=0 has no effect.

Decomposition:
- Shared package/header:
  - ONE and ZERO constants derived from WIDTH/FRAC_WIDTH.
  - FSM state encoding.
  - Fixed-point multiply-truncate function, shared with the existing fixed-point multiply block.
- One sub-module, fix_point_sqrt_seq:
  - Start/done handshake.
  - 2*WIDTH-bit radicand, WIDTH-bit root.
  - Exactly WIDTH cycles from start to done.
- Dividers stay inline: two instances of a small restoring loop sharing one iteration counter.

Test Plan:
(WIDTH=32, FRAC_WIDTH=30, ONE=0x4000_0000; results within TOL_LSB.)
1. Head-on elastic: p0=(0,0), p1=(0.5,0), v0=(0.5,0), v1=(0,0), e=ONE -> new_v0=(0,0), new_v1=(0.5,0), flags 0, out_valid at cycle 69.
2. Glancing 45°: p1=(0.5,0.5), other inputs as in test 1 -> new_v0=(0.25,-0.25), new_v1=(0.25,0.25).
3. Inelastic: test 1 stimulus with e=0 -> new_v0=(0.25,0), new_v1=(0.25,0).
4. Separating and degenerate:
   - v0=(-0.5,0), rest as test 1 -> separating=1, outputs equal inputs, out_valid at cycle 68.
   - p1=p0 -> degenerate=1, pass-through, out_valid at cycle 2.
5. Backpressure and reset:
   - out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout; the pair completes on the first out_ready=1 edge.
   - rst pulsed low at cycle 30 -> all outputs 0 immediately; no stale out_valid; next pair resolves correctly.

Source files
------------

// File: rtl/collision_resolver_seq_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the collision resolver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package collision_resolver_seq_pkg;

    localparam int CR_WIDTH      = 32;
    localparam int CR_FRAC_WIDTH = 30;

    // Q(CR_FRAC_WIDTH) unity and zero at the default operand width.
    localparam logic [CR_WIDTH-1:0] CR_ONE  = CR_WIDTH'(1) << CR_FRAC_WIDTH;
    localparam logic [CR_WIDTH-1:0] CR_ZERO = '0;

    // Widest operand the shared multiply helper supports; callers sign-extend into it.
    localparam int FX_MAXW = 64;

    typedef enum logic [3:0] {
        IDLE,
        DIFF,
        MAG,
        SQRT,
        DIV,
        DOT,
        IMPULSE,
        APPLY,
        HOLD
    } cr_state_t;

    // Full-precision signed product, arithmetic shift by frac, truncated back to
    // the operand width. Callers narrow the result to their own WIDTH.
    function automatic logic signed [FX_MAXW-1:0] fx_mul(
        input logic signed [FX_MAXW-1:0] a,
        input logic signed [FX_MAXW-1:0] b,
        input int                        frac
    );
        logic signed [2*FX_MAXW-1:0] p;
        p = (2*FX_MAXW)'(a) * (2*FX_MAXW)'(b);
        return FX_MAXW'(p >>> frac);
    endfunction

endpackage

// File: rtl/collision_resolver_seq_sqrt.sv
// fix_point_sqrt_seq: bit-serial restoring integer square root, one root bit per cycle.
// Latency: done pulses exactly WIDTH cycles after start; root holds until the next start.
// Backpressure: none; start is only accepted when the caller knows the unit is idle.
// Ports: clk, rst (async active-low), start, radicand[2*WIDTH], done, root[WIDTH].
module fix_point_sqrt_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] radicand,
    output logic               done,
    output logic [WIDTH-1:0]   root
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] rad_q;
    logic [WIDTH+1:0]   rem_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    logic [WIDTH+1:0]   rem_cur, rem_sh, trial, rem_nxt;
    logic [WIDTH-1:0]   root_cur, root_nxt;
    logic [1:0]         pair;
    logic               bit_set;

    // The first iteration is taken straight from the radicand on the start edge,
    // so WIDTH iterations finish WIDTH cycles after start was presented.
    always_comb begin
        rem_cur  = start ? '0 : rem_q;
        root_cur = start ? '0 : root;
        pair     = start ? radicand[2*WIDTH-1 -: 2] : rad_q[2*WIDTH-1 -: 2];
        rem_sh   = (rem_cur << 2) | (WIDTH+2)'(pair);
        trial    = {root_cur, 2'b01};
        bit_set  = (rem_sh >= trial);
        rem_nxt  = bit_set ? (rem_sh - trial) : rem_sh;
        root_nxt = (root_cur << 1) | WIDTH'(bit_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rad_q  <= radicand << 2;
                rem_q  <= rem_nxt;
                root   <= root_nxt;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rad_q <= rad_q << 2;
                rem_q <= rem_nxt;
                root  <= root_nxt;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/collision_resolver_seq.sv
// Equal-mass 2D ball collision resolver with runtime restitution; separating/coincident pairs pass through.
// Latency: out_valid 2*WIDTH+5 cycles after accept (separating 2*WIDTH+4, degenerate 2); not pipelined.
// Backpressure: in_ready only when idle; result and flags held in HOLD until out_valid&out_ready.
// Ports: clk, rst (async active-low), in_valid/in_ready, x0,y0,x1,y1, v0_*, v1_*, restitution,
//        out_valid/out_ready, new_v0_*, new_v1_*, separating, degenerate.
module collision_resolver_seq
    import collision_resolver_seq_pkg::*;
#(
    parameter int WIDTH      = CR_WIDTH,
    parameter int FRAC_WIDTH = CR_FRAC_WIDTH,
    parameter int TOL_LSB    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] v0_x,
    input  logic [WIDTH-1:0] v0_y,
    input  logic [WIDTH-1:0] v1_x,
    input  logic [WIDTH-1:0] v1_y,
    input  logic [WIDTH-1:0] restitution,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] new_v0_x,
    output logic [WIDTH-1:0] new_v0_y,
    output logic [WIDTH-1:0] new_v1_x,
    output logic [WIDTH-1:0] new_v1_y,
    output logic             separating,
    output logic             degenerate
);
    localparam int CW = $clog2(WIDTH);
    localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(64'(1) << FRAC_WIDTH);

    function automatic logic signed [WIDTH-1:0] fmul(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return WIDTH'(fx_mul(FX_MAXW'(a), FX_MAXW'(b), FRAC_WIDTH));
    endfunction

    cr_state_t state_q, state_nxt;

    logic signed [WIDTH-1:0] x0_r, y0_r, x1_r, y1_r, v0x_r, v0y_r, v1x_r, v1y_r, e_r;
    logic signed [WIDTH-1:0] dx_r, dy_r, rvx_r, rvy_r, vn_r, s_r;

    logic [WIDTH:0]   remx_q, remy_q;
    logic [WIDTH-1:0] lowx_q, lowy_q, qx_q, qy_q;
    logic             sx_q, sy_q;
    logic [CW-1:0]    div_cnt;

    logic               xfer, sq_start, sq_done, load_pass;
    logic [WIDTH-1:0]   sq_root;
    logic [2*WIDTH-1:0] d2;
    logic signed [2*WIDTH-1:0] dx_sq, dy_sq;

    // Squared distance is a sum of squares, so it is carried unsigned to keep
    // the one extra bit the sum of two extreme squares needs.
    always_comb begin
        dx_sq = (2*WIDTH)'(dx_r) * (2*WIDTH)'(dx_r);
        dy_sq = (2*WIDTH)'(dy_r) * (2*WIDTH)'(dy_r);
        d2    = $unsigned(dx_sq) + $unsigned(dy_sq);
    end

    fix_point_sqrt_seq #(.WIDTH(WIDTH)) u_sqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand (d2),
        .done     (sq_done),
        .root     (sq_root)
    );

    // Dividers work on magnitudes; the sign is reapplied to the quotient.
    logic [WIDTH-1:0]   mag_dx, mag_dy;
    logic [2*WIDTH-1:0] numx, numy;
    logic [WIDTH:0]     den, remx_sh, remy_sh, remx_nxt, remy_nxt;
    logic [WIDTH-1:0]   qx_nxt, qy_nxt;
    logic               qbx, qby;
    logic signed [WIDTH-1:0] n_x, n_y, k;
    logic signed [WIDTH:0]   k_sum;

    always_comb begin
        mag_dx   = dx_r[WIDTH-1] ? $unsigned(-dx_r) : $unsigned(dx_r);
        mag_dy   = dy_r[WIDTH-1] ? $unsigned(-dy_r) : $unsigned(dy_r);
        numx     = (2*WIDTH)'(mag_dx) << FRAC_WIDTH;
        numy     = (2*WIDTH)'(mag_dy) << FRAC_WIDTH;
        den      = {1'b0, sq_root};
        remx_sh  = (remx_q << 1) | (WIDTH+1)'(lowx_q[WIDTH-1]);
        remy_sh  = (remy_q << 1) | (WIDTH+1)'(lowy_q[WIDTH-1]);
        qbx      = (remx_sh >= den);
        qby      = (remy_sh >= den);
        remx_nxt = qbx ? (remx_sh - den) : remx_sh;
        remy_nxt = qby ? (remy_sh - den) : remy_sh;
        qx_nxt   = (qx_q << 1) | WIDTH'(qbx);
        qy_nxt   = (qy_q << 1) | WIDTH'(qby);
        n_x      = sx_q ? -$signed(qx_q) : $signed(qx_q);
        n_y      = sy_q ? -$signed(qy_q) : $signed(qy_q);
        // One extra bit so e = ONE does not wrap before the halving.
        k_sum    = (WIDTH+1)'(e_r) + (WIDTH+1)'(ONE_W);
        k        = WIDTH'(k_sum >>> 1);
    end

    always_comb begin
        state_nxt = state_q;
        xfer      = 1'b0;
        sq_start  = 1'b0;
        load_pass = 1'b0;
        case (state_q)
            IDLE:    if (in_valid && in_ready) begin
                         xfer      = 1'b1;
                         state_nxt = DIFF;
                     end
            DIFF:    state_nxt = MAG;
            MAG:     if (d2 == '0) begin
                         load_pass = 1'b1;
                         state_nxt = HOLD;
                     end else begin
                         sq_start  = 1'b1;
                         state_nxt = SQRT;
                     end
            SQRT:    if (sq_done) state_nxt = DIV;
            DIV:     if (div_cnt == CW'(WIDTH-1)) state_nxt = DOT;
            DOT:     state_nxt = IMPULSE;
            IMPULSE: if (vn_r[WIDTH-1]) begin
                         state_nxt = APPLY;
                     end else begin
                         load_pass = 1'b1;
                         state_nxt = HOLD;
                     end
            APPLY:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state_q == HOLD);

    // in_ready is registered so it stays low during reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            in_ready <= (state_nxt == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {x0_r, y0_r, x1_r, y1_r, v0x_r, v0y_r, v1x_r, v1y_r, e_r} <= '0;
            {dx_r, dy_r, rvx_r, rvy_r, vn_r, s_r} <= '0;
            {remx_q, remy_q, lowx_q, lowy_q, qx_q, qy_q} <= '0;
            {sx_q, sy_q} <= '0;
            div_cnt    <= '0;
            new_v0_x   <= '0;
            new_v0_y   <= '0;
            new_v1_x   <= '0;
            new_v1_y   <= '0;
            separating <= 1'b0;
            degenerate <= 1'b0;
        end else begin
            if (xfer) begin
                x0_r <= x0;    y0_r <= y0;    x1_r <= x1;    y1_r <= y1;
                v0x_r <= v0_x; v0y_r <= v0_y; v1x_r <= v1_x; v1y_r <= v1_y;
                e_r  <= restitution;
                separating <= 1'b0;
                degenerate <= 1'b0;
            end
            if (load_pass) begin
                new_v0_x <= v0x_r; new_v0_y <= v0y_r;
                new_v1_x <= v1x_r; new_v1_y <= v1y_r;
                if (state_q == MAG) degenerate <= 1'b1;
                else                separating <= 1'b1;
            end
            case (state_q)
                DIFF: begin
                    dx_r  <= x1_r - x0_r;
                    dy_r  <= y1_r - y0_r;
                    rvx_r <= v1x_r - v0x_r;
                    rvy_r <= v1y_r - v0y_r;
                end
                SQRT: if (sq_done) begin
                    remx_q  <= {1'b0, numx[2*WIDTH-1:WIDTH]};
                    remy_q  <= {1'b0, numy[2*WIDTH-1:WIDTH]};
                    lowx_q  <= numx[WIDTH-1:0];
                    lowy_q  <= numy[WIDTH-1:0];
                    qx_q    <= '0;
                    qy_q    <= '0;
                    sx_q    <= dx_r[WIDTH-1];
                    sy_q    <= dy_r[WIDTH-1];
                    div_cnt <= '0;
                end
                DIV: begin
                    remx_q  <= remx_nxt;
                    remy_q  <= remy_nxt;
                    lowx_q  <= lowx_q << 1;
                    lowy_q  <= lowy_q << 1;
                    qx_q    <= qx_nxt;
                    qy_q    <= qy_nxt;
                    div_cnt <= div_cnt + 1'b1;
                end
                DOT:     vn_r <= fmul(rvx_r, n_x) + fmul(rvy_r, n_y);
                IMPULSE: if (vn_r[WIDTH-1]) s_r <= fmul(k, vn_r);
                APPLY: begin
                    new_v0_x <= v0x_r + fmul(s_r, n_x);
                    new_v0_y <= v0y_r + fmul(s_r, n_y);
                    new_v1_x <= v1x_r - fmul(s_r, n_x);
                    new_v1_y <= v1y_r - fmul(s_r, n_y);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_resolver_seq.sv
// Self-checking bench for collision_resolver_seq: scoreboard of expected results, latency and handshake checks.
// Latency: measured per pair from the accept edge to out_valid.
// Backpressure: exercises held out_ready, early out_ready and mid-operation reset.
module tb_collision_resolver_seq;

    localparam int TOL = 4;
    localparam logic [31:0] ONE   = 32'h4000_0000;
    localparam logic [31:0] TQTR  = 32'h3000_0000;
    localparam logic [31:0] HALF  = 32'h2000_0000;
    localparam logic [31:0] QTR   = 32'h1000_0000;
    localparam logic [31:0] NHALF = 32'hE000_0000;
    localparam logic [31:0] NQTR  = 32'hF000_0000;

    typedef struct {
        logic [31:0] x0, y0, x1, y1, v0x, v0y, v1x, v1y, e;
    } stim_t;

    typedef struct {
        logic [31:0] v0x, v0y, v1x, v1y;
        logic        sep, deg;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] x0, y0, x1, y1, v0_x, v0_y, v1_x, v1_y, restitution;
    logic [31:0] new_v0_x, new_v0_y, new_v1_x, new_v1_y;
    logic        separating, degenerate;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    collision_resolver_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .v0_x        (v0_x),
        .v0_y        (v0_y),
        .v1_x        (v1_x),
        .v1_y        (v1_y),
        .restitution (restitution),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .new_v0_x    (new_v0_x),
        .new_v0_y    (new_v0_y),
        .new_v1_x    (new_v1_x),
        .new_v1_y    (new_v1_y),
        .separating  (separating),
        .degenerate  (degenerate)
    );

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    task automatic check(input string tag, input longint obs, input longint expv, input longint tol);
        longint diff;
        n_checks++;
        diff = obs - expv;
        if (diff < 0) diff = -diff;
        if (diff <= tol) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                      tag, obs, obs, expv, expv, tol);
    endtask

    function automatic stim_t mk_stim(input logic [31:0] px0, py0, px1, py1,
                                      input logic [31:0] a0x, a0y, a1x, a1y, ee);
        stim_t s;
        s.x0 = px0; s.y0 = py0; s.x1 = px1; s.y1 = py1;
        s.v0x = a0x; s.v0y = a0y; s.v1x = a1x; s.v1y = a1y; s.e = ee;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] a0x, a0y, a1x, a1y,
                                    input logic sp, dg, input int lt);
        exp_t e;
        e.v0x = a0x; e.v0y = a0y; e.v1x = a1x; e.v1y = a1y;
        e.sep = sp; e.deg = dg; e.lat = lt;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        x0 = s.x0; y0 = s.y0; x1 = s.x1; y1 = s.y1;
        v0_x = s.v0x; v0_y = s.v0y; v1_x = s.v1x; v1_y = s.v1y;
        restitution = s.e;
    endtask

    task automatic scramble();
        x0 = $urandom; y0 = $urandom; x1 = $urandom; y1 = $urandom;
        v0_x = $urandom; v0_y = $urandom; v1_x = $urandom; v1_y = $urandom;
        restitution = $urandom;
    endtask

    task automatic check_outs(input string nm, input exp_t e);
        check({nm, ".v0x"}, sx(new_v0_x), sx(e.v0x), TOL);
        check({nm, ".v0y"}, sx(new_v0_y), sx(e.v0y), TOL);
        check({nm, ".v1x"}, sx(new_v1_x), sx(e.v1x), TOL);
        check({nm, ".v1y"}, sx(new_v1_y), sx(e.v1y), TOL);
        check({nm, ".sep"}, longint'(separating), longint'(e.sep), 0);
        check({nm, ".deg"}, longint'(degenerate), longint'(e.deg), 0);
    endtask

    task automatic accept(input stim_t s, input string nm, output logic ok);
        int n;
        @(negedge clk);
        drive(s);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({nm, ".accept"}, longint'(in_ready), 1, 0);
        ok = in_ready;
        if (ok) @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic run_pair(input string nm, input stim_t s, input exp_t e,
                            input int hold, input logic early);
        int   n;
        logic ok;
        exp_t got;
        sb.push_back(e);
        out_ready = early;
        accept(s, nm, ok);
        if (!ok) begin
            got = sb.pop_front();
            return;
        end
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        got = sb.pop_front();
        check({nm, ".out_valid"}, longint'(out_valid), 1, 0);
        if (!out_valid) return;
        check({nm, ".latency"}, n, got.lat, 0);
        check_outs(nm, got);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({nm, ".hold_vld"}, longint'(out_valid), 1, 0);
            check({nm, ".hold_rdy"}, longint'(in_ready), 0, 0);
            check_outs({nm, ".hold"}, got);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({nm, ".drain_vld"}, longint'(out_valid), 0, 0);
        check({nm, ".drain_rdy"}, longint'(in_ready), 1, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        stim_t s_head;
        logic  ok;
        int    stale;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));

        #12;
        check("reset.in_ready", longint'(in_ready), 0, 0);
        check("reset.out_valid", longint'(out_valid), 0, 0);
        check_outs("reset", mk_exp(0, 0, 0, 0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset.release_rdy", longint'(in_ready), 1, 0);

        s_head = mk_stim(0, 0, HALF, 0, HALF, 0, 0, 0, ONE);

        run_pair("headon", s_head, mk_exp(0, 0, HALF, 0, 1'b0, 1'b0, 69), 0, 1'b0);
        run_pair("glance", mk_stim(0, 0, HALF, HALF, HALF, 0, 0, 0, ONE),
                 mk_exp(QTR, NQTR, QTR, QTR, 1'b0, 1'b0, 69), 0, 1'b0);
        run_pair("inelastic", mk_stim(0, 0, HALF, 0, HALF, 0, 0, 0, 0),
                 mk_exp(QTR, 0, QTR, 0, 1'b0, 1'b0, 69), 0, 1'b0);
        run_pair("offset", mk_stim(QTR, QTR, TQTR, QTR, HALF, QTR, NQTR, HALF, ONE),
                 mk_exp(NQTR, QTR, HALF, HALF, 1'b0, 1'b0, 69), 0, 1'b0);
        run_pair("yaxis", mk_stim(0, 0, 0, NHALF, 0, NHALF, 0, 0, ONE),
                 mk_exp(0, 0, 0, NHALF, 1'b0, 1'b0, 69), 0, 1'b0);
        run_pair("separating", mk_stim(0, 0, HALF, 0, NHALF, 0, 0, 0, ONE),
                 mk_exp(NHALF, 0, 0, 0, 1'b1, 1'b0, 68), 0, 1'b0);
        run_pair("degenerate", mk_stim(0, 0, 0, 0, HALF, 0, 0, 0, ONE),
                 mk_exp(HALF, 0, 0, 0, 1'b0, 1'b1, 2), 0, 1'b0);
        run_pair("backpressure", s_head, mk_exp(0, 0, HALF, 0, 1'b0, 1'b0, 69), 10, 1'b0);
        run_pair("early_ready", mk_stim(0, 0, HALF, 0, HALF, 0, 0, 0, 0),
                 mk_exp(QTR, 0, QTR, 0, 1'b0, 1'b0, 69), 0, 1'b1);

        // Abort a pair part-way through with reset.
        accept(s_head, "abort", ok);
        repeat (29) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort.in_ready", longint'(in_ready), 0, 0);
        check("abort.out_valid", longint'(out_valid), 0, 0);
        check_outs("abort", mk_exp(0, 0, 0, 0, 1'b0, 1'b0, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("abort.rdy_at_release", longint'(in_ready), 0, 0);
        @(posedge clk);
        #1;
        check("abort.rdy_after_release", longint'(in_ready), 1, 0);
        stale = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("abort.stale_valid", stale, 0, 0);

        run_pair("after_reset", s_head, mk_exp(0, 0, HALF, 0, 1'b0, 1'b0, 69), 0, 1'b0);

        check("scoreboard.empty", sb.size(), 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
